// File: rtl/spi_flash_reader.sv
// SPI mode-0 NOR flash word reader: wakes the flash with 0xAB, then serves each
// bus read with a 0x03 command and returns one little-endian 32-bit word.
module spi_flash_reader #(
   parameter int CLK_DIV = 1,
   parameter int CS_HIGH = 2,
   parameter int T_RES   = 100
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [23:0] addr_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        busy_o,
   output logic        sck_o,
   output logic        sdo_o,
   input  logic        sdi_i,
   output logic        cs_o
);

   localparam logic [2:0] S_WAKE      = 3'd0;
   localparam logic [2:0] S_WAKE_WAIT = 3'd1;
   localparam logic [2:0] S_IDLE      = 3'd2;
   localparam logic [2:0] S_XFER      = 3'd3;
   localparam logic [2:0] S_DESEL     = 3'd4;

   localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
   localparam logic [31:0] TRES_LAST = 32'(T_RES - 1);
   localparam logic [31:0] CSH_LAST  = 32'(CS_HIGH - 1);

   logic [2:0]  state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [6:0]  bit_q, bit_d;
   logic [31:0] wait_q, wait_d;
   logic [31:0] tx_q, tx_d;
   logic [31:0] rx_q, rx_d;
   logic        sck_q, sck_d;
   logic        sdo_q, sdo_d;
   logic        cs_q, cs_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        busy_q, busy_d;

   logic        shifting;
   logic        done;
   logic [6:0]  last_bit;
   logic        load_en;
   logic [31:0] load_word;

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      wait_d    = wait_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      sck_d     = sck_q;
      sdo_d     = sdo_q;
      cs_d      = cs_q;
      rvalid_d  = 1'b0;
      rdata_d   = rdata_q;
      done      = 1'b0;
      load_en   = 1'b0;
      load_word = 32'h0;

      // WAKE spends its first cycle with cs high; shifting starts once cs is low.
      shifting = (state_q == S_XFER) || ((state_q == S_WAKE) && !cs_q);
      last_bit = (state_q == S_XFER) ? 7'd63 : 7'd7;

      if (shifting) begin
         if (div_q == DIV_LAST) begin
            div_d = 16'd0;
            sck_d = ~sck_q;
            if (!sck_q) begin
               rx_d = {rx_q[30:0], sdi_i};
            end else if (bit_q == last_bit) begin
               done = 1'b1;
            end else begin
               bit_d = bit_q + 7'd1;
               sdo_d = tx_q[31];
               tx_d  = {tx_q[30:0], 1'b0};
            end
         end else begin
            div_d = div_q + 16'd1;
         end
      end

      case (state_q)
         S_WAKE: begin
            if (cs_q) begin
               load_en   = 1'b1;
               load_word = {8'hAB, 24'h0};
            end else if (done) begin
               cs_d    = 1'b1;
               sdo_d   = 1'b0;
               wait_d  = 32'd0;
               state_d = S_WAKE_WAIT;
            end
         end
         S_WAKE_WAIT: begin
            if (wait_q == TRES_LAST) state_d = S_IDLE;
            else                     wait_d  = wait_q + 32'd1;
         end
         S_IDLE: begin
            if (req_i) begin
               load_en   = 1'b1;
               load_word = {8'h03, addr_i};
               state_d   = S_XFER;
            end
         end
         S_XFER: begin
            if (done) begin
               cs_d     = 1'b1;
               rvalid_d = 1'b1;
               // First received byte lands in the least significant lane.
               rdata_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
               wait_d   = 32'd0;
               state_d  = S_DESEL;
            end
         end
         S_DESEL: begin
            if (wait_q == CSH_LAST) state_d = S_IDLE;
            else                    wait_d  = wait_q + 32'd1;
         end
         default: state_d = S_WAKE;
      endcase

      if (load_en) begin
         cs_d  = 1'b0;
         sck_d = 1'b0;
         div_d = 16'd0;
         bit_d = 7'd0;
         sdo_d = load_word[31];
         tx_d  = {load_word[30:0], 1'b0};
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_WAKE;
         div_q    <= 16'd0;
         bit_q    <= 7'd0;
         wait_q   <= 32'd0;
         tx_q     <= 32'd0;
         rx_q     <= 32'd0;
         sck_q    <= 1'b0;
         sdo_q    <= 1'b0;
         cs_q     <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'd0;
         busy_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         wait_q   <= wait_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         sck_q    <= sck_d;
         sdo_q    <= sdo_d;
         cs_q     <= cs_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
      end
   end

   assign gnt_o    = (state_q == S_IDLE) && req_i;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign busy_o   = busy_q;
   assign sck_o    = sck_q;
   assign sdo_o    = sdo_q;
   assign cs_o     = cs_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: one instance at CLK_DIV=1, one at CLK_DIV=3,
// each with a small SPI flash model on its pins.
module tb_spi_flash_reader;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1 = 1'b1, req1 = 1'b0, sdi1 = 1'b0;
   logic [23:0] addr1 = 24'h0;
   logic        gnt1, rvalid1, busy1, sck1, sdo1, cs1;
   logic [31:0] rdata1;

   logic        rst3 = 1'b1, req3 = 1'b0, sdi3 = 1'b0;
   logic [23:0] addr3 = 24'h0;
   logic        gnt3, rvalid3, busy3, sck3, sdo3, cs3;
   logic [31:0] rdata3;

   int errors = 0;
   int checks = 0;

   spi_flash_reader #(.CLK_DIV(1), .CS_HIGH(2), .T_RES(100)) dut1 (
      .clk_i(clk), .rst_i(rst1), .req_i(req1), .addr_i(addr1), .gnt_o(gnt1),
      .rvalid_o(rvalid1), .rdata_o(rdata1), .busy_o(busy1), .sck_o(sck1),
      .sdo_o(sdo1), .sdi_i(sdi1), .cs_o(cs1)
   );

   spi_flash_reader #(.CLK_DIV(3), .CS_HIGH(2), .T_RES(100)) dut3 (
      .clk_i(clk), .rst_i(rst3), .req_i(req3), .addr_i(addr3), .gnt_o(gnt3),
      .rvalid_o(rvalid3), .rdata_o(rdata3), .busy_o(busy3), .sck_o(sck3),
      .sdo_o(sdo3), .sdi_i(sdi3), .cs_o(cs3)
   );

   // Flash models: capture MOSI on rising SCK, drive MISO on falling SCK.
   // resp holds the four returned bytes, first byte in [31:24].
   logic [31:0] resp1 = 32'h0, resp3 = 32'h0;
   logic [63:0] mosi_sr1 = 64'h0, mosi_sr3 = 64'h0;
   int cnt1 = 0, cnt3 = 0, last_cnt1 = 0, last_cnt3 = 0;

   always @(posedge sck1 or posedge cs1) begin
      if (cs1) begin
         last_cnt1 <= cnt1;
         cnt1      <= 0;
      end else begin
         cnt1     <= cnt1 + 1;
         mosi_sr1 <= {mosi_sr1[62:0], sdo1};
      end
   end
   always @(negedge sck1) sdi1 <= (cnt1 >= 32 && cnt1 < 64) ? resp1[63 - cnt1] : 1'b0;

   always @(posedge sck3 or posedge cs3) begin
      if (cs3) begin
         last_cnt3 <= cnt3;
         cnt3      <= 0;
      end else begin
         cnt3     <= cnt3 + 1;
         mosi_sr3 <= {mosi_sr3[62:0], sdo3};
      end
   end
   always @(negedge sck3) sdi3 <= (cnt3 >= 32 && cnt3 < 64) ? resp3[63 - cnt3] : 1'b0;

   // Protocol monitor on both instances.
   int   mon_viol = 0;
   logic psck1 = 1'b0, psdo1 = 1'b0, psck3 = 1'b0, psdo3 = 1'b0;
   always @(negedge clk) begin
      if (cs1 === 1'b1 && sck1 !== 1'b0) mon_viol = mon_viol + 1;
      if (cs3 === 1'b1 && sck3 !== 1'b0) mon_viol = mon_viol + 1;
      if (sck1 === 1'b1 && psck1 === 1'b1 && sdo1 !== psdo1) mon_viol = mon_viol + 1;
      if (sck3 === 1'b1 && psck3 === 1'b1 && sdo3 !== psdo3) mon_viol = mon_viol + 1;
      psck1 = sck1; psdo1 = sdo1; psck3 = sck3; psdo3 = sdo3;
   end

   // Issues one read; reports rvalid cycle (relative to the grant cycle), data,
   // and how many SCK phases while cs was low did not last the expected length.
   task automatic run_read(input bit sel, input logic [23:0] a, input logic [31:0] r,
                           output int lat, output logic [31:0] d, output int bad_phase);
      bit   g;
      int   run, phase;
      logic ps, cs, sk;
      lat = -1; d = 32'h0; bad_phase = 0; g = 1'b0; run = 0; ps = 1'b0;
      phase = sel ? 3 : 1;
      if (sel) begin resp3 = r; addr3 = a; req3 = 1'b1; end
      else     begin resp1 = r; addr1 = a; req1 = 1'b1; end
      for (int i = 0; i < 400 && !g; i++) begin
         @(negedge clk);
         g = sel ? gnt3 : gnt1;
      end
      @(posedge clk);
      #1;
      req1 = 1'b0; req3 = 1'b0;
      if (!g) return;
      for (int c = 1; c <= 600; c++) begin
         @(negedge clk);
         cs = sel ? cs3 : cs1;
         sk = sel ? sck3 : sck1;
         if ((sel ? rvalid3 : rvalid1) === 1'b1) begin
            lat = c;
            d   = sel ? rdata3 : rdata1;
            break;
         end
         if (cs === 1'b0) begin
            if (c > 1 && sk !== ps) begin
               if (run != phase) bad_phase++;
               run = 0;
            end
            run++;
            ps = sk;
         end
      end
      if (run != phase) bad_phase++;
   endtask

   task automatic test_reset;
      rst1 = 1'b1; rst3 = 1'b1; req1 = 1'b0; req3 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (cs1 !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", cs1); end
      checks++; if (sck1 !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", sck1); end
      checks++; if (sdo1 !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b expected 0", sdo1); end
      checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", gnt1); end
      checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid1); end
      checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata1); end
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy1); end
      checks++; if (cs3 !== 1'b1) begin errors++; $display("FAIL reset_cs_div3: got %b expected 1", cs3); end
      @(posedge clk);
      #1;
      rst1 = 1'b0; rst3 = 1'b0;
   endtask

   task automatic test_wake;
      int low, high;
      low = 0; high = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cs1 === 1'b0) break;
      end
      for (int i = 0; i < 100; i++) begin
         if (cs1 !== 1'b0) break;
         low++;
         @(negedge clk);
      end
      for (int i = 0; i < 300; i++) begin
         if (!(busy1 === 1'b1 && cs1 === 1'b1)) break;
         high++;
         @(negedge clk);
      end
      checks++; if (low != 16) begin errors++; $display("FAIL wake_cs_low_cycles: got %0d expected 16", low); end
      checks++; if (last_cnt1 != 8) begin errors++; $display("FAIL wake_sck_pulses: got %0d expected 8", last_cnt1); end
      checks++; if (mosi_sr1[7:0] !== 8'hAB) begin errors++; $display("FAIL wake_opcode: got %h expected ab", mosi_sr1[7:0]); end
      checks++; if (high != 100) begin errors++; $display("FAIL wake_wait_cycles: got %0d expected 100", high); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL wake_busy_after: got %b expected 0", busy1); end
   endtask

   task automatic test_read;
      int lat, bp;
      logic [31:0] d;
      run_read(1'b0, 24'h200000, 32'h13050000, lat, d, bp);
      checks++; if (lat != 129) begin errors++; $display("FAIL read_latency: got %0d expected 129", lat); end
      checks++; if (d !== 32'h00000513) begin errors++; $display("FAIL read_data: got %h expected 00000513", d); end
      checks++; if (mosi_sr1[63:32] !== 32'h03200000) begin errors++; $display("FAIL read_mosi_cmd: got %h expected 03200000", mosi_sr1[63:32]); end
      checks++; if (mosi_sr1[31:0] !== 32'h0) begin errors++; $display("FAIL read_mosi_data_phase: got %h expected 00000000", mosi_sr1[31:0]); end
      checks++; if (bp != 0) begin errors++; $display("FAIL read_sck_phase: got %0d bad phases expected 0", bp); end
      @(negedge clk);
      checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL read_rvalid_pulse: got %b expected 0", rvalid1); end
      checks++; if (rdata1 !== 32'h00000513) begin errors++; $display("FAIL read_rdata_hold: got %h expected 00000513", rdata1); end
   endtask

   task automatic test_back_to_back;
      int rv, g2, csh;
      bit g, got;
      logic [31:0] d;
      rv = -1; g2 = -1; csh = 0; g = 1'b0; got = 1'b0; d = 32'h0;
      resp1 = 32'hA1B2C3D4; addr1 = 24'h000100; req1 = 1'b1;
      for (int i = 0; i < 400 && !g; i++) begin
         @(negedge clk);
         g = gnt1;
      end
      for (int c = 1; c < 300 && g; c++) begin
         @(negedge clk);
         if (c == 1) addr1 = 24'h000104;
         if (gnt1 === 1'b1) begin g2 = c; break; end
         if (rvalid1 === 1'b1) begin rv = c; d = rdata1; end
         if (rv >= 0 && cs1 === 1'b1) csh++;
      end
      @(posedge clk);
      #1;
      req1 = 1'b0;
      checks++; if (rv != 129) begin errors++; $display("FAIL b2b_first_rvalid: got %0d expected 129", rv); end
      checks++; if (g2 != 131) begin errors++; $display("FAIL b2b_second_gnt: got %0d expected 131", g2); end
      checks++; if (csh != 2) begin errors++; $display("FAIL b2b_cs_high: got %0d expected 2", csh); end
      checks++; if (d !== 32'hD4C3B2A1) begin errors++; $display("FAIL b2b_first_data: got %h expected d4c3b2a1", d); end
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (rvalid1 === 1'b1) begin got = 1'b1; break; end
      end
      checks++; if (!got || rdata1 !== 32'hD4C3B2A1) begin errors++; $display("FAIL b2b_second_data: got %h valid %b expected d4c3b2a1", rdata1, got); end
      checks++; if (mosi_sr1[63:32] !== 32'h03000104) begin errors++; $display("FAIL b2b_second_cmd: got %h expected 03000104", mosi_sr1[63:32]); end
   endtask

   task automatic test_clkdiv3;
      int lat, bp;
      logic [31:0] d;
      for (int i = 0; i < 400; i++) begin
         if (busy3 === 1'b0) break;
         @(negedge clk);
      end
      run_read(1'b1, 24'h000003, 32'h11223344, lat, d, bp);
      checks++; if (lat != 385) begin errors++; $display("FAIL div3_latency: got %0d expected 385", lat); end
      checks++; if (d !== 32'h44332211) begin errors++; $display("FAIL div3_data: got %h expected 44332211", d); end
      checks++; if (mosi_sr3[63:32] !== 32'h03000003) begin errors++; $display("FAIL div3_mosi_cmd: got %h expected 03000003", mosi_sr3[63:32]); end
      checks++; if (bp != 0) begin errors++; $display("FAIL div3_sck_phase: got %0d bad phases expected 0", bp); end
   endtask

   task automatic test_reset_mid_xfer;
      bit g;
      int rvs, lat, bp;
      logic [31:0] d;
      g = 1'b0; rvs = 0;
      resp1 = 32'h55667788; addr1 = 24'h123456; req1 = 1'b1;
      for (int i = 0; i < 400 && !g; i++) begin
         @(negedge clk);
         g = gnt1;
      end
      @(posedge clk);
      #1;
      req1 = 1'b0;
      repeat (39) @(posedge clk);
      #1;
      rst1 = 1'b1;
      @(posedge clk);
      #1;
      rst1 = 1'b0;
      @(negedge clk);
      checks++; if (!g || cs1 !== 1'b1) begin errors++; $display("FAIL midrst_cs: got %b granted %b expected 1", cs1, g); end
      checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h expected 00000000", rdata1); end
      for (int i = 0; i < 400; i++) begin
         if (rvalid1 === 1'b1) rvs++;
         @(negedge clk);
         if (busy1 === 1'b0) break;
      end
      checks++; if (rvs != 0) begin errors++; $display("FAIL midrst_no_rvalid: got %0d pulses expected 0", rvs); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL midrst_rewake_done: got busy %b expected 0", busy1); end
      checks++; if (mosi_sr1[7:0] !== 8'hAB || last_cnt1 != 8) begin errors++; $display("FAIL midrst_rewake_opcode: got %h over %0d bits expected ab over 8", mosi_sr1[7:0], last_cnt1); end
      run_read(1'b0, 24'h00ABCD, 32'hDEADBEEF, lat, d, bp);
      checks++; if (lat != 129) begin errors++; $display("FAIL midrst_next_latency: got %0d expected 129", lat); end
      checks++; if (d !== 32'hEFBEADDE) begin errors++; $display("FAIL midrst_next_data: got %h expected efbeadde", d); end
      checks++; if (mosi_sr1[63:32] !== 32'h0300ABCD) begin errors++; $display("FAIL midrst_next_cmd: got %h expected 0300abcd", mosi_sr1[63:32]); end
   endtask

   task automatic test_protocol;
      checks++; if (mon_viol != 0) begin errors++; $display("FAIL protocol_monitor: got %0d violations expected 0", mon_viol); end
   endtask

   initial begin
      test_reset();
      test_wake();
      test_read();
      test_back_to_back();
      test_clkdiv3();
      test_reset_mid_xfer();
      repeat (5) @(negedge clk);
      test_protocol();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
